// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the execute-stage ALU. ALUController drives Operation using
// alu_op_e, so both sides agree on the encoding. alu_state_e names the states
// of the sequential wrapper.
// No ports; this is a package.
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_EQ  = 4'b1000,
    ALU_SRA = 4'b1010,
    ALU_SLT = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  // Shifts take the multi-cycle path; everything else is a one-cycle op.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// -----------------------------------------------------------------------------
// alu_comb_core
// Purely combinational one-cycle ALU ops: AND, OR, ADD, SUB, XOR, SLT, EQ.
// Shift codes and unknown codes produce 0 here; the sequential wrapper
// handles shifts on its own.
// Ports:
//   op      in   OPCODE_LENGTH  operation code (alu_op_e encoding)
//   a       in   DATA_WIDTH     operand A
//   b       in   DATA_WIDTH     operand B
//   result  out  DATA_WIDTH     combinational result
// -----------------------------------------------------------------------------
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [OPCODE_LENGTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  output logic [DATA_WIDTH-1:0]    result
);

  logic lessThan;
  logic equal;

  assign lessThan = ($signed(a) < $signed(b));
  assign equal    = (a == b);

  // ADD/SUB wrap naturally at DATA_WIDTH bits; SLT/EQ yield a 0/1 result.
  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, lessThan};
      ALU_EQ:  result = {{(DATA_WIDTH-1){1'b0}}, equal};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Logic/arithmetic ops complete in one cycle; shifts walk one bit per cycle
// through an accumulator so no barrel shifter is required.
// Ports:
//   clk        in   1              rising-edge clock
//   reset      in   1              synchronous, active-high
//   in_valid   in   1              Operation/SrcA/SrcB valid
//   in_ready   out  1              block can accept an op (IDLE)
//   Operation  in   OPCODE_LENGTH  op code (alu_op_e)
//   SrcA       in   DATA_WIDTH     operand A / shift source
//   SrcB       in   DATA_WIDTH     operand B; low bits are the shift amount
//   out_valid  out  1              ALUResult/Zero valid (DONE)
//   out_ready  in   1              consumer takes the result
//   ALUResult  out  DATA_WIDTH     registered result
//   Zero       out  1              registered (ALUResult == 0)
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  localparam int SHW = $clog2(DATA_WIDTH);

  alu_state_e               state,     stateNext;
  logic [DATA_WIDTH-1:0]    acc,       accNext;
  logic [SHW-1:0]           cnt,       cntNext;
  logic [OPCODE_LENGTH-1:0] opReg,     opNext;
  logic [DATA_WIDTH-1:0]    resultReg, resultNext;
  logic                     zeroReg,   zeroNext;

  logic [DATA_WIDTH-1:0]    coreResult;
  logic [DATA_WIDTH-1:0]    oneCycleResult;
  logic [DATA_WIDTH-1:0]    accShifted;
  logic [SHW-1:0]           shamt;
  logic                     shiftOp;

  alu_comb_core #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_core (
    .op    (Operation),
    .a     (SrcA),
    .b     (SrcB),
    .result(coreResult)
  );

  assign shamt   = SrcB[SHW-1:0];
  assign shiftOp = is_shift_op(Operation);

  // A shift by zero is just SrcA and is finished on the one-cycle path.
  assign oneCycleResult = shiftOp ? SrcA : coreResult;

  // One bit of the shift per cycle, direction/fill chosen by the latched op.
  always_comb begin
    accShifted = acc;
    case (opReg)
      ALU_SLL: accShifted = acc << 1;
      ALU_SRL: accShifted = acc >> 1;
      default: accShifted = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
    endcase
  end

  // State register plus all datapath registers; everything returns to the
  // idle/empty condition on reset, discarding any in-flight shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      opReg     <= '0;
      resultReg <= '0;
      zeroReg   <= 1'b1;
    end else begin
      state     <= stateNext;
      acc       <= accNext;
      cnt       <= cntNext;
      opReg     <= opNext;
      resultReg <= resultNext;
      zeroReg   <= zeroNext;
    end
  end

  // Next-state logic. Inputs are only looked at in IDLE; the result
  // registers change only when an op completes, so they hold through DONE.
  always_comb begin
    stateNext  = state;
    accNext    = acc;
    cntNext    = cnt;
    opNext     = opReg;
    resultNext = resultReg;
    zeroNext   = zeroReg;
    case (state)
      IDLE: begin
        if (in_valid) begin
          opNext = Operation;
          if (shiftOp && (shamt != '0)) begin
            accNext   = SrcA;
            cntNext   = shamt;
            stateNext = SHIFT;
          end else begin
            resultNext = oneCycleResult;
            zeroNext   = (oneCycleResult == '0);
            stateNext  = DONE;
          end
        end
      end
      SHIFT: begin
        accNext = accShifted;
        cntNext = cnt - 1'b1;
        // cnt==1 means this cycle applies the last bit of the shift.
        if (cnt == SHW'(1)) begin
          resultNext = accShifted;
          zeroNext   = (accShifted == '0);
          stateNext  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign ALUResult = resultReg;
  assign Zero      = zeroReg;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq: directed cases from the block's intended
// behaviour followed by random ops, all compared against an arithmetic
// reference model of result, Zero and latency.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int nAsserts = 0;
  int nFail    = 0;
  logic [31:0] lastResult;
  logic        lastZero;
  int          lastLatency;

  alu_seq #(
    .DATA_WIDTH   (32),
    .OPCODE_LENGTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Operation(Operation),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .Zero     (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result straight from the op-code table.
  function automatic logic [31:0] refResult(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0100: return a ^ b;
      4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      4'b0011: return a << sh;
      4'b0101: return a >> sh;
      4'b1010: return $signed(a) >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  // Edges from the accepting edge up to out_valid: shamt+1 for real shifts.
  function automatic int refLatency(input logic [3:0] op, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if ((op == 4'b0011 || op == 4'b0101 || op == 4'b1010) && sh != 0)
      return sh + 1;
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One complete transaction: present, wait for the result while poking
  // in_valid and scrambling inputs, hold out_ready low, then hand off.
  task automatic applyStimulus(input string tag, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input int hold);
    logic [31:0] expRes;
    int          expLat;
    int          edges;
    expRes = refResult(op, a, b);
    expLat = refLatency(op, b);
    checkOutput({tag, "_ready_before"}, 64'(in_ready), 64'd1);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      Operation = 4'($urandom);
      SrcA      = $urandom;
      SrcB      = $urandom;
      in_valid  = 1'($urandom);
      checkOutput({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
    end while (!out_valid && edges < 100);
    lastLatency = edges;
    lastResult  = ALUResult;
    lastZero    = Zero;
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_latency"}, 64'(edges), 64'(expLat));
    checkOutput({tag, "_result"}, 64'(ALUResult), 64'(expRes));
    checkOutput({tag, "_zero"}, 64'(Zero), 64'(expRes == 32'd0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'($urandom);
      checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, "_hold_result"}, 64'(ALUResult), 64'(expRes));
      checkOutput({tag, "_hold_zero"}, 64'(Zero), 64'(expRes == 32'd0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_after_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_after_ready"}, 64'(in_ready), 64'd1);
  endtask

  logic [3:0] opList [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100,
                              4'b1100, 4'b1000, 4'b0011, 4'b0101, 4'b1010,
                              4'b1111};

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Operation = 4'b0000;
    SrcA      = '0;
    SrcB      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", 64'(ALUResult), 64'd0);
    checkOutput("rst_zero", 64'(Zero), 64'd1);

    applyStimulus("add", 4'b0010, 32'd5, 32'd7, 0);
    checkOutput("add_spec", 64'(lastResult), 64'd12);
    checkOutput("add_spec_lat", 64'(lastLatency), 64'd1);
    applyStimulus("sub_neg", 4'b0110, 32'd3, 32'd5, 0);
    checkOutput("sub_neg_spec", 64'(lastResult), 64'hFFFF_FFFE);
    applyStimulus("sub_zero", 4'b0110, 32'd9, 32'd9, 0);
    checkOutput("sub_zero_spec", 64'(lastZero), 64'd1);
    applyStimulus("slt", 4'b1100, 32'hFFFF_FFFF, 32'd1, 0);
    checkOutput("slt_spec", 64'(lastResult), 64'd1);
    applyStimulus("eq", 4'b1000, 32'd7, 32'd7, 0);
    checkOutput("eq_spec", 64'(lastResult), 64'd1);
    applyStimulus("sll31", 4'b0011, 32'd1, 32'd31, 0);
    checkOutput("sll31_spec", 64'(lastResult), 64'h8000_0000);
    checkOutput("sll31_spec_lat", 64'(lastLatency), 64'd32);
    applyStimulus("sra4", 4'b1010, 32'h8000_0000, 32'd4, 0);
    checkOutput("sra4_spec", 64'(lastResult), 64'hF800_0000);
    checkOutput("sra4_spec_lat", 64'(lastLatency), 64'd5);
    applyStimulus("srl4", 4'b0101, 32'h8000_0000, 32'd4, 0);
    checkOutput("srl4_spec", 64'(lastResult), 64'h0800_0000);
    applyStimulus("sll0", 4'b0011, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0);
    checkOutput("sll0_spec", 64'(lastResult), 64'hDEAD_BEEF);
    applyStimulus("hold", 4'b0100, 32'h1234_5678, 32'h0F0F_0F0F, 3);
    applyStimulus("hold_shift", 4'b0011, 32'h0000_0003, 32'd6, 3);
    applyStimulus("badop", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Reset in the middle of a 20-bit SRL, when 10 shifts remain.
    Operation = 4'b0101;
    SrcA      = 32'hFFFF_FFFF;
    SrcB      = 32'd20;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_busy", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_result", 64'(ALUResult), 64'd0);
    checkOutput("midrst_zero", 64'(Zero), 64'd1);
    applyStimulus("post_rst_add", 4'b0010, 32'd100, 32'd23, 0);
    checkOutput("post_rst_add_spec", 64'(lastResult), 64'd123);

    for (int n = 0; n < 40; n++) begin
      rop = opList[$urandom_range(10, 0)];
      ra  = $urandom;
      rb  = ($urandom_range(3, 0) == 0) ? ra : 32'($urandom);
      applyStimulus("rand", rop, ra, rb, $urandom_range(2, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
